// File: rtl/sprite_animator.sv
// Animated-sprite renderer: steps a frame index through a sprite-sheet strip on VGA
// frame ticks and produces a registered sheet ROM address plus a pixel-hit flag.
module sprite_animator #(
    parameter int SPR_W      = 10,
    parameter int SPR_H      = 10,
    parameter int NUM_FRAMES = 4,
    parameter int SHEET_X    = 0,
    parameter int SHEET_Y    = 20,
    parameter int IMG_W      = 320,
    parameter int IMG_PIX    = 76800,
    parameter int STEP_DIV   = 8,
    parameter int FLASH_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        frame_tick,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [8:0]  obj_x,
    input  logic [8:0]  obj_y,
    input  logic [1:0]  anim_mode,
    input  logic        anim_start,
    input  logic        flip_h,
    input  logic        flash,
    output logic [16:0] pixel_addr,
    output logic        isObject,
    output logic [3:0]  frame_idx,
    output logic        anim_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD     = 2'b00;
    localparam logic [1:0] MODE_LOOP     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;
    localparam logic [1:0] MODE_PINGPONG = 2'b11;

    localparam int SCW = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
    localparam int FCW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [3:0]     LAST_F     = 4'(NUM_FRAMES - 1);
    localparam logic [SCW-1:0] STEP_LAST  = SCW'(STEP_DIV - 1);
    localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_DIV - 1);

    localparam logic [31:0] SX_C  = SHEET_X;
    localparam logic [31:0] SY_C  = SHEET_Y;
    localparam logic [31:0] SW_C  = SPR_W;
    localparam logic [31:0] IW_C  = IMG_W;
    localparam logic [31:0] IP_C  = IMG_PIX;

    state_t         state_q, state_d;
    logic [3:0]     frame_q, frame_d;
    logic [SCW-1:0] step_q, step_d;
    logic           dir_up_q, dir_up_d;
    logic           done_q, done_d;
    logic [FCW-1:0] flash_cnt_q, flash_cnt_d;
    logic           visible_q, visible_d;

    logic [3:0]     fc;
    logic [3:0]     oneshot_next;
    logic           mode_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            step_q      <= '0;
            dir_up_q    <= 1'b1;
            done_q      <= 1'b0;
            flash_cnt_q <= '0;
            visible_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            step_q      <= step_d;
            dir_up_q    <= dir_up_d;
            done_q      <= done_d;
            flash_cnt_q <= flash_cnt_d;
            visible_q   <= visible_d;
        end
    end

    // Animation control: en and anim_start act on any clk, everything else waits for a tick.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        step_d       = step_q;
        dir_up_d     = dir_up_q;
        done_d       = 1'b0;
        mode_hold    = (anim_mode == MODE_HOLD);
        fc           = (frame_q > LAST_F) ? LAST_F : frame_q;
        oneshot_next = (fc == LAST_F) ? LAST_F : fc + 4'd1;

        if (!en) begin
            state_d  = S_IDLE;
            frame_d  = '0;
            step_d   = '0;
            dir_up_d = 1'b1;
        end else if (anim_start) begin
            frame_d  = '0;
            step_d   = '0;
            dir_up_d = 1'b1;
            state_d  = mode_hold ? S_HOLD : S_RUN;
        end else if (frame_tick) begin
            case (state_q)
                S_IDLE: begin
                    state_d = mode_hold ? S_HOLD : S_RUN;
                    frame_d = '0;
                    step_d  = '0;
                end
                S_RUN: begin
                    if (step_q != STEP_LAST) begin
                        step_d = step_q + SCW'(1);
                    end else begin
                        step_d  = '0;
                        frame_d = fc;
                        case (anim_mode)
                            MODE_HOLD: state_d = S_HOLD;
                            MODE_LOOP: frame_d = (fc == LAST_F) ? 4'd0 : fc + 4'd1;
                            MODE_ONESHOT: begin
                                frame_d = oneshot_next;
                                if (oneshot_next == LAST_F) begin
                                    state_d = S_DONE;
                                    done_d  = 1'b1;
                                end
                            end
                            MODE_PINGPONG: begin
                                // Reverse on reaching an end so each end frame shows once.
                                if (LAST_F == 4'd0) begin
                                    frame_d = 4'd0;
                                end else if (dir_up_q) begin
                                    if (fc == LAST_F) begin
                                        dir_up_d = 1'b0;
                                        frame_d  = fc - 4'd1;
                                    end else begin
                                        frame_d  = fc + 4'd1;
                                    end
                                end else begin
                                    if (fc == 4'd0) begin
                                        dir_up_d = 1'b1;
                                        frame_d  = 4'd1;
                                    end else begin
                                        frame_d  = fc - 4'd1;
                                    end
                                end
                            end
                            default: state_d = S_RUN;
                        endcase
                    end
                end
                S_HOLD: begin
                    if (!mode_hold) begin
                        state_d = S_RUN;
                        step_d  = '0;
                        frame_d = fc;
                    end
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Blink: first tick with flash high hides the sprite, then it toggles every FLASH_DIV ticks.
    always_comb begin
        flash_cnt_d = flash_cnt_q;
        visible_d   = visible_q;
        if (!flash) begin
            flash_cnt_d = '0;
            visible_d   = 1'b1;
        end else if (frame_tick) begin
            if (flash_cnt_q == '0) begin
                visible_d = ~visible_q;
            end
            flash_cnt_d = (flash_cnt_q == FLASH_LAST) ? '0 : flash_cnt_q + FCW'(1);
        end
    end

    logic [9:0]  px, py, ox, oy, rx, ry, dx;
    logic        in_x, in_y, hit;
    logic [31:0] addr_full;
    logic [16:0] addr_d;

    always_comb begin
        px        = h_cnt >> 1;
        py        = v_cnt >> 1;
        ox        = {1'b0, obj_x};
        oy        = {1'b0, obj_y};
        in_x      = (px >= ox) && (px < ox + 10'(SPR_W));
        in_y      = (py >= oy) && (py < oy + 10'(SPR_H));
        rx        = px - ox;
        ry        = py - oy;
        dx        = flip_h ? (10'(SPR_W - 1) - rx) : rx;
        hit       = en && in_x && in_y && (visible_q || !flash);
        addr_full = SX_C + 32'(dx) + SW_C * 32'(frame_q) + (SY_C + 32'(ry)) * IW_C;
        addr_d    = 17'(addr_full % IP_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
            isObject   <= 1'b0;
        end else begin
            pixel_addr <= hit ? addr_d : 17'd0;
            isObject   <= hit;
        end
    end

    assign frame_idx = frame_q;
    assign anim_done = done_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed spec scenarios plus randomized traffic, all checked
// every clock against a behavioural model of the animation, blink and addressing rules.
module tb_sprite_animator;

    localparam int NF = 4;
    localparam int SD = 2;
    localparam int FD = 2;
    localparam int SW = 10;
    localparam int SH = 10;
    localparam int SX = 0;
    localparam int SY = 20;
    localparam int IW = 320;
    localparam int IP = 76800;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_HOLD = 2;
    localparam int P_DONE = 3;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        frame_tick;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [8:0]  obj_x;
    logic [8:0]  obj_y;
    logic [1:0]  anim_mode;
    logic        anim_start;
    logic        flip_h;
    logic        flash;
    logic [16:0] pixel_addr;
    logic        isObject;
    logic [3:0]  frame_idx;
    logic        anim_done;

    sprite_animator #(
        .SPR_W(SW), .SPR_H(SH), .NUM_FRAMES(NF), .SHEET_X(SX), .SHEET_Y(SY),
        .IMG_W(IW), .IMG_PIX(IP), .STEP_DIV(SD), .FLASH_DIV(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_tick(frame_tick),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .obj_x(obj_x), .obj_y(obj_y),
        .anim_mode(anim_mode), .anim_start(anim_start), .flip_h(flip_h), .flash(flash),
        .pixel_addr(pixel_addr), .isObject(isObject), .frame_idx(frame_idx), .anim_done(anim_done)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int m_phase, m_frame, m_cnt, m_dir, m_fticks, e_addr;
    bit m_done, e_obj;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_frame = 0; m_cnt = 0; m_dir = 1; m_fticks = 0;
        m_done = 0; e_obj = 0; e_addr = 0;
    endtask

    task automatic model_advance();
        case (int'(anim_mode))
            0: m_phase = P_HOLD;
            1: m_frame = (m_frame + 1) % NF;
            2: begin
                m_frame = (m_frame + 1 > NF - 1) ? NF - 1 : m_frame + 1;
                if (m_frame == NF - 1) begin
                    m_phase = P_DONE;
                    m_done  = 1;
                end
            end
            default: begin
                if (NF == 1) m_frame = 0;
                else if (m_dir > 0 && m_frame >= NF - 1) begin m_dir = -1; m_frame = m_frame - 1; end
                else if (m_dir < 0 && m_frame == 0) begin m_dir = 1; m_frame = 1; end
                else m_frame = m_frame + m_dir;
            end
        endcase
    endtask

    task automatic model_edge();
        int x, y, ox, oy, dx, dy;
        bit vis;
        if (!rst_n) begin
            model_reset();
            return;
        end
        x  = int'(h_cnt) / 2;
        y  = int'(v_cnt) / 2;
        ox = int'(obj_x);
        oy = int'(obj_y);
        vis = !flash || (m_fticks == 0) || (((m_fticks - 1) / FD) % 2 == 1);
        e_obj = en && x >= ox && x < ox + SW && y >= oy && y < oy + SH && vis;
        dx = flip_h ? SW - 1 - (x - ox) : x - ox;
        dy = y - oy;
        e_addr = e_obj ? (SX + dx + SW * m_frame + (SY + dy) * IW) % IP : 0;

        m_done = 0;
        if (!en) begin
            m_phase = P_IDLE; m_frame = 0; m_cnt = 0; m_dir = 1;
        end else if (anim_start) begin
            m_frame = 0; m_cnt = 0; m_dir = 1;
            m_phase = (anim_mode == 2'b00) ? P_HOLD : P_RUN;
        end else if (frame_tick) begin
            if (m_phase == P_IDLE) begin
                m_phase = (anim_mode == 2'b00) ? P_HOLD : P_RUN;
            end else if (m_phase == P_HOLD) begin
                if (anim_mode != 2'b00) begin m_phase = P_RUN; m_cnt = 0; end
            end else if (m_phase == P_RUN) begin
                m_cnt++;
                if (m_cnt == SD) begin
                    m_cnt = 0;
                    model_advance();
                end
            end
        end

        if (!flash) m_fticks = 0;
        else if (frame_tick) m_fticks++;
    endtask

    // driver tasks
    task automatic step_clk();
        @(posedge clk);
        model_edge();
        #1;
        chk("frame_idx", 32'(frame_idx), 32'(m_frame));
        chk("anim_done", 32'(anim_done), 32'(m_done));
        chk("isObject", 32'(isObject), 32'(e_obj));
        chk("pixel_addr", 32'(pixel_addr), 32'(e_addr));
    endtask

    task automatic tick_cycle();
        frame_tick = 1'b1;
        step_clk();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        anim_start = 1'b1;
        step_clk();
        anim_start = 1'b0;
    endtask

    int loop_exp[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int pp_exp[7]    = '{1, 2, 3, 2, 1, 0, 1};
    int flash_exp[5] = '{0, 0, 1, 1, 0};

    initial begin
        rst_n = 1'b0; en = 1'b0; frame_tick = 1'b0; h_cnt = '0; v_cnt = '0;
        obj_x = 9'd100; obj_y = 9'd50; anim_mode = 2'b01; anim_start = 1'b0;
        flip_h = 1'b0; flash = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_frame", 32'(frame_idx), 0);
        chk("rst_done", 32'(anim_done), 0);
        chk("rst_obj", 32'(isObject), 0);
        chk("rst_addr", 32'(pixel_addr), 0);
        rst_n = 1'b1;
        step_clk();

        // LOOP entered from IDLE
        en = 1'b1;
        anim_mode = 2'b01;
        for (int i = 0; i < 9; i++) begin
            tick_cycle();
            chk("loop_seq", 32'(frame_idx), 32'(loop_exp[i]));
            step_clk();
        end

        // ONESHOT
        anim_mode = 2'b10;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            tick_cycle();
            if (i < 5) step_clk();
        end
        chk("oneshot_frame", 32'(frame_idx), 3);
        chk("oneshot_done", 32'(anim_done), 1);
        step_clk();
        chk("oneshot_done_clr", 32'(anim_done), 0);
        for (int i = 0; i < 4; i++) begin
            tick_cycle();
            step_clk();
        end
        chk("oneshot_stay", 32'(frame_idx), 3);
        pulse_start();
        chk("oneshot_restart", 32'(frame_idx), 0);

        // PINGPONG
        anim_mode = 2'b11;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            tick_cycle();
            tick_cycle();
            chk("pingpong_seq", 32'(frame_idx), 32'(pp_exp[i]));
        end

        // HOLD, then a mode change releases it
        anim_mode = 2'b00;
        pulse_start();
        for (int i = 0; i < 4; i++) tick_cycle();
        chk("hold_frozen", 32'(frame_idx), 0);
        anim_mode = 2'b01;
        for (int i = 0; i < 5; i++) tick_cycle();

        // pixel addressing at frame 2
        pulse_start();
        for (int i = 0; i < 4; i++) tick_cycle();
        obj_x = 9'd100; obj_y = 9'd50; h_cnt = 10'd206; v_cnt = 10'd108; flip_h = 1'b0;
        step_clk();
        chk("pix_frame", 32'(frame_idx), 2);
        chk("pix_addr", 32'(pixel_addr), 7703);
        chk("pix_hit", 32'(isObject), 1);
        flip_h = 1'b1;
        step_clk();
        chk("pix_addr_flip", 32'(pixel_addr), 7706);
        flip_h = 1'b0;
        h_cnt = 10'd218;
        step_clk();
        chk("edge_x109", 32'(isObject), 1);
        h_cnt = 10'd220;
        step_clk();
        chk("edge_x110", 32'(isObject), 0);
        obj_x = 9'd315; h_cnt = 10'd638;
        step_clk();
        chk("edge_x319", 32'(isObject), 1);

        // flash blink pattern with pixel inside
        obj_x = 9'd100; h_cnt = 10'd206;
        flash = 1'b1;
        step_clk();
        for (int i = 0; i < 5; i++) begin
            tick_cycle();
            step_clk();
            chk("flash_pat", 32'(isObject), 32'(flash_exp[i]));
        end
        flash = 1'b0;
        step_clk();
        chk("flash_drop", 32'(isObject), 1);

        // en low mid-run
        en = 1'b0;
        step_clk();
        chk("en_off_frame", 32'(frame_idx), 0);
        chk("en_off_obj", 32'(isObject), 0);
        en = 1'b1;

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) begin
                obj_x = 9'($urandom_range(2, 315));
                obj_y = 9'($urandom_range(2, 230));
            end
            frame_tick = ($urandom_range(0, 3) == 0);
            anim_start = ($urandom_range(0, 29) == 0);
            en = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 39) == 0) anim_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) flash = ~flash;
            flip_h = 1'($urandom_range(0, 1));
            h_cnt = 10'(2 * (int'(obj_x) + $urandom_range(0, 13) - 2) + $urandom_range(0, 1));
            v_cnt = 10'(2 * (int'(obj_y) + $urandom_range(0, 13) - 2) + $urandom_range(0, 1));
            step_clk();
        end
        frame_tick = 1'b0; anim_start = 1'b0; en = 1'b1; flash = 1'b0;

        // asynchronous reset during a run
        obj_x = 9'd100; obj_y = 9'd50; h_cnt = 10'd206; v_cnt = 10'd108;
        anim_mode = 2'b01;
        pulse_start();
        for (int i = 0; i < 4; i++) tick_cycle();
        step_clk();
        chk("pre_rst_frame", 32'(frame_idx), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_frame", 32'(frame_idx), 0);
        chk("arst_obj", 32'(isObject), 0);
        chk("arst_addr", 32'(pixel_addr), 0);
        chk("arst_done", 32'(anim_done), 0);
        model_reset();
        step_clk();
        rst_n = 1'b1;
        repeat (3) step_clk();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
